// File: rtl/pm_update4_pkg.sv
// Shared decoder definitions: default metric/LLR widths, list size and the
// saturation ceiling used by the path-metric update and by Sorter4.
package pm_update4_pkg;

    localparam int PM_WIDTH_DEF  = 8;
    localparam int LLR_WIDTH_DEF = 6;
    localparam int LIST_SIZE     = 4;

    // Largest unsigned path metric for a given width (all-ones).
    function automatic int unsigned pm_max_of(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pm_update4_cas.sv
// Compare-and-swap cell: routes the smaller operand to lo, the larger to hi.
// Equal operands keep their order, so the sort stays stable.
module pm_update4_cas #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic swap;

    // Swap only when b is strictly smaller than a.
    always_comb begin
        swap = (b < a);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

// File: rtl/pm_update4.sv
// Path-metric update for a list-4 SC decoder. Information bits produce eight
// candidate metrics handed to Sorter4, whose four survivors are written back.
// Frozen bits update the metrics in place and re-sort them with a 4-cycle
// odd-even transposition network built from two CAS cells.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high; a valid, once raised, holds its payload until that edge.
// pm_wb_valid has no ready: it is only honoured while waiting for write-back.
module pm_update4
    import pm_update4_pkg::*;
#(
    parameter int PM_WIDTH  = PM_WIDTH_DEF,
    parameter int LLR_WIDTH = LLR_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         frozen_in,
    input  logic [LLR_WIDTH*4-1:0]       llr_in,
    output logic [PM_WIDTH*8-1:0]        cand_out,
    output logic                         cand_valid,
    input  logic                         cand_ready,
    input  logic [PM_WIDTH*4-1:0]        pm_wb_in,
    input  logic                         pm_wb_valid,
    output logic [PM_WIDTH*4-1:0]        pm_out,
    output logic [2:0]                   state_dbg
);

    localparam int L  = LIST_SIZE;
    localparam int SW = ((PM_WIDTH > LLR_WIDTH) ? PM_WIDTH : LLR_WIDTH) + 1;
    localparam logic [PM_WIDTH-1:0] PM_MAX = PM_WIDTH'(pm_max_of(PM_WIDTH));

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CAND    = 3'd1;
    localparam logic [2:0] WAIT_WB = 3'd2;
    localparam logic [2:0] SORT0   = 3'd3;
    localparam logic [2:0] SORT1   = 3'd4;
    localparam logic [2:0] SORT2   = 3'd5;
    localparam logic [2:0] SORT3   = 3'd6;

    // Ascending-order order packing: index 0 lands in the MSB slice.
    logic [0:L-1][PM_WIDTH-1:0]    pm_q, pm_d, pm_init, pm_wb_v;
    logic [0:2*L-1][PM_WIDTH-1:0]  cand_q, cand_d;
    logic [0:L-1][LLR_WIDTH-1:0]   llr_v, neg_v;
    logic [0:L-1][LLR_WIDTH-2:0]   pen;
    logic [0:L-1][PM_WIDTH-1:0]    pm_pen;
    logic [2:0]                    state_q, state_d;
    logic                          cand_valid_q, cand_valid_d;
    logic                          in_ready_q;
    logic                          even_phase;
    logic [PM_WIDTH-1:0]           cas_a_a, cas_a_b, cas_a_lo, cas_a_hi;
    logic [PM_WIDTH-1:0]           cas_b_lo, cas_b_hi;

    assign llr_v   = llr_in;
    assign pm_wb_v = pm_wb_in;
    assign pm_init = {{PM_WIDTH{1'b0}}, PM_MAX, PM_MAX, PM_MAX};

    function automatic logic [PM_WIDTH-1:0] sat_add(input logic [PM_WIDTH-1:0] a,
                                                    input logic [LLR_WIDTH-2:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return (s > SW'(PM_MAX)) ? PM_MAX : s[PM_WIDTH-1:0];
    endfunction

    // Penalty |llr| per path; the most-negative code clips to the largest positive.
    always_comb begin
        for (int l = 0; l < L; l++) begin
            neg_v[l] = ~llr_v[l] + {{(LLR_WIDTH-1){1'b0}}, 1'b1};
            if (!llr_v[l][LLR_WIDTH-1])
                pen[l] = llr_v[l][LLR_WIDTH-2:0];
            else if (llr_v[l] == {1'b1, {(LLR_WIDTH-1){1'b0}}})
                pen[l] = '1;
            else
                pen[l] = neg_v[l][LLR_WIDTH-2:0];
            pm_pen[l] = sat_add(pm_q[l], pen[l]);
        end
    end

    // Sort network wiring: even phases sort (0,1)/(2,3), odd phases sort (1,2).
    always_comb begin
        even_phase = (state_q == SORT0) || (state_q == SORT2);
        cas_a_a    = even_phase ? pm_q[0] : pm_q[1];
        cas_a_b    = even_phase ? pm_q[1] : pm_q[2];
    end

    pm_update4_cas #(.W(PM_WIDTH)) u_cas_a (
        .a  (cas_a_a),
        .b  (cas_a_b),
        .lo (cas_a_lo),
        .hi (cas_a_hi)
    );

    pm_update4_cas #(.W(PM_WIDTH)) u_cas_b (
        .a  (pm_q[2]),
        .b  (pm_q[3]),
        .lo (cas_b_lo),
        .hi (cas_b_hi)
    );

    // Next-state and datapath selection; start overrides every other event.
    always_comb begin
        state_d      = state_q;
        pm_d         = pm_q;
        cand_d       = cand_q;
        cand_valid_d = cand_valid_q;
        if (start) begin
            state_d      = IDLE;
            pm_d         = pm_init;
            cand_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (frozen_in) begin
                            for (int l = 0; l < L; l++)
                                pm_d[l] = llr_v[l][LLR_WIDTH-1] ? pm_pen[l] : pm_q[l];
                            state_d = SORT0;
                        end else begin
                            for (int l = 0; l < L; l++) begin
                                cand_d[2*l]   = pm_q[l];
                                cand_d[2*l+1] = pm_pen[l];
                            end
                            cand_valid_d = 1'b1;
                            state_d      = CAND;
                        end
                    end
                end
                CAND: begin
                    if (cand_ready) begin
                        cand_valid_d = 1'b0;
                        state_d      = WAIT_WB;
                    end
                end
                WAIT_WB: begin
                    if (pm_wb_valid) begin
                        pm_d    = pm_wb_v;
                        state_d = IDLE;
                    end
                end
                SORT0, SORT2: begin
                    pm_d[0] = cas_a_lo;
                    pm_d[1] = cas_a_hi;
                    pm_d[2] = cas_b_lo;
                    pm_d[3] = cas_b_hi;
                    state_d = (state_q == SORT0) ? SORT1 : SORT3;
                end
                SORT1, SORT3: begin
                    pm_d[1] = cas_a_lo;
                    pm_d[2] = cas_a_hi;
                    state_d = (state_q == SORT1) ? SORT2 : IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, metric, candidate and ready registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pm_q         <= pm_init;
            cand_q       <= '0;
            cand_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            pm_q         <= pm_d;
            cand_q       <= cand_d;
            cand_valid_q <= cand_valid_d;
            in_ready_q   <= (state_d == IDLE);
        end
    end

    assign in_ready   = in_ready_q;
    assign cand_out   = cand_q;
    assign cand_valid = cand_valid_q;
    assign pm_out     = pm_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/pm_update4.md
PM_UPDATE4 -- requirements
Module: pm_update4

Interface
REQ-001 SHALL have parameter PM_WIDTH, default 8: unsigned path-metric width.
REQ-002 SHALL have parameter LLR_WIDTH, default 6: signed two's-complement LLR width; list size L=4 fixed as localparam.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  new-codeword strobe.
REQ-006 SHALL have port in_valid  input  1 and in_ready  output  1  bit-step handshake.
REQ-007 SHALL have port frozen_in  input  1  1 = frozen bit (value 0), 0 = information bit.
REQ-008 SHALL have port llr_in  input  LLR_WIDTH*4  per-path decision LLR, path 0 in MSB slice.
REQ-009 SHALL have port cand_out  output  PM_WIDTH*8  candidate PMs {c0..c7}, c0 in MSB slice (feeds Sorter4 PM_in).
REQ-010 SHALL have port cand_valid  output  1 and cand_ready  input  1  candidate handshake.
REQ-011 SHALL have port pm_wb_in  input  PM_WIDTH*4  sorted survivors (Sorter4 PM_out), with pm_wb_valid  input  1.
REQ-012 SHALL have port pm_out  output  PM_WIDTH*4  current PM registers, path 0 in MSB slice.

Function
REQ-013 SHALL define PM_MAX = 2^PM_WIDTH-1; all PM additions saturate at PM_MAX.
REQ-014 SHALL compute pen_l = |llr_l|, most-negative LLR mapped to 2^(LLR_WIDTH-1)-1.
REQ-015 SHALL implement states IDLE, CAND, WAIT_WB, SORT0..SORT3; in_ready = (state==IDLE).
REQ-016 SHALL, on info-bit accept in IDLE, register c(2l)=PM_l and c(2l+1)=sat(PM_l+pen_l), go CAND; cand_valid high the following cycle.
REQ-017 SHALL hold cand_out/cand_valid stable in CAND until cand_ready sampled high, then go WAIT_WB with cand_valid low.
REQ-018 SHALL, in WAIT_WB, on pm_wb_valid load pm_wb_in into the PM registers and return to IDLE; pm_wb_valid outside WAIT_WB ignored.
REQ-019 SHALL, on frozen-bit accept in IDLE, load PM_l <= sat(PM_l + (llr_l<0 ? pen_l : 0)), then run SORT0..SORT3 (one cycle each) and return to IDLE.
REQ-020 SHALL, in SORT0/SORT2, compare-swap pairs (0,1),(2,3); in SORT1/SORT3, pair (1,2); ascending, ties not swapped.
REQ-021 SHALL guarantee PM registers ascending (PM_0<=PM_1<=PM_2<=PM_3) whenever state==IDLE, so candidates satisfy c(2l)<=c(2l+1) and c(2l)<=c(2l+2).
REQ-022 SHALL, on start in any state, set PM={0,PM_MAX,PM_MAX,PM_MAX}, drop cand_valid, go IDLE; start has priority over all other events.
REQ-023 SHALL, when start and in_valid coincide, process start only; in_ready stays high so the bit is accepted next cycle.
REQ-024 SHALL have latency: info accept edge N -> cand_valid at N+1; frozen accept edge N -> in_ready high again after edge N+4.

Reset
REQ-025 SHALL, on rst, set state IDLE, pm_out={0,PM_MAX,PM_MAX,PM_MAX}, cand_out all zero, cand_valid 0, in_ready 1.
REQ-026 SHALL abort any operation when rst asserts mid-step; no partial write-back survives.

Structure
REQ-027 SHALL place PM_MAX derivation and PM_WIDTH/LLR_WIDTH defaults in the shared decoder package/include common to Sorter4.
REQ-028 SHALL reuse the existing CAS sub-module (two instances) for SORT-phase compare-swaps.
REQ-029 SHALL register all outputs; no combinational path from llr_in to cand_out.

Verification (PM_WIDTH=8, LLR_WIDTH=6)
REQ-030 SHALL cover reset: rst pulse -> pm_out={0,255,255,255}, in_ready=1, cand_valid=0.
REQ-031 SHALL cover info bit after start, llr={+5,-3,+7,0} -> next cycle cand_out={0,5,255,255,255,255,255,255}, cand_valid=1.
REQ-032 SHALL cover backpressure: cand_ready low 3 cycles -> cand_out stable, in_ready=0; write-back {0,5,255,255} -> pm_out matches, in_ready=1.
REQ-033 SHALL cover frozen re-sort: PM={2,4,6,8}, llr={-7,+1,-1,-32} -> sums {9,4,7,39}, after 4 SORT cycles pm_out={4,7,9,39}.
REQ-034 SHALL cover saturation: PM_0=250, llr_0=-32, info bit -> c1=255; frozen -> PM_0=255.
REQ-035 SHALL cover start asserted in CAND -> cand_valid drops next cycle, pm_out={0,255,255,255}, later pm_wb_valid ignored.
